// File: rtl/imm_pipe_unit_if.sv
// Handshake and result bundle for imm_pipe_unit.
// The slave modport is the unit's own view; master is the driver/consumer side.
interface imm_pipe_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       fmt_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  modport master (
    output in_valid_i, instr_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, illegal_cnt_o
  );

  modport slave (
    input  in_valid_i, instr_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/imm_pipe_unit.sv
// imm_pipe_unit: RV32I/RV64I immediate generator with a one-entry
// valid/ready output register, flush, and a saturating illegal-opcode counter.
// Optional feature macro: IMM_ZICSR_EN (CSR uimm decode for SYSTEM opcode).
module imm_pipe_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  imm_pipe_unit_if.slave bus
);

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [2:0] FMT_NONE    = 3'd0;
  localparam logic [2:0] FMT_I       = 3'd1;
  localparam logic [2:0] FMT_S       = 3'd2;
  localparam logic [2:0] FMT_B       = 3'd3;
  localparam logic [2:0] FMT_U       = 3'd4;
  localparam logic [2:0] FMT_J       = 3'd5;
  localparam logic [2:0] FMT_Z       = 3'd6;
  localparam logic [2:0] FMT_ILLEGAL = 3'd7;

  logic [31:0]        ins;
  logic [2:0]         dec_fmt;
  logic signed [31:0] dec_imm32;
  logic               dec_illegal;

  logic               out_valid_q;
  logic [XLEN-1:0]    imm_q;
  logic [2:0]         fmt_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;

  assign ins = bus.instr_i;

  // Decode opcode into format and a 32-bit signed immediate; widened to XLEN on load.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    dec_fmt     = FMT_NONE;
    dec_imm32   = '0;
    dec_illegal = 1'b0;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {ins[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_REG, OP_FENCE: begin
        dec_fmt   = FMT_NONE;
      end
      OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
        // CSRRWI/CSRRSI/CSRRCI carry a 5-bit unsigned immediate in the rs1 field.
        if (ins[14:12] inside {3'd5, 3'd6, 3'd7}) begin
          dec_fmt   = FMT_Z;
          dec_imm32 = {27'b0, ins[19:15]};
        end
`else
        // Without CSR immediate support every SYSTEM op carries no immediate.
        dec_fmt   = FMT_NONE;
        dec_imm32 = '0;
`endif
      end
      default: begin
        dec_fmt     = FMT_ILLEGAL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Ready whenever the slot is empty or being drained this cycle.
  assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;
  assign accept         = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;

  // Output register: flush beats accept, accept beats a plain transfer.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      fmt_q       <= FMT_NONE;
      illegal_q   <= 1'b0;
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      imm_q       <= XLEN'(dec_imm32);
      fmt_q       <= dec_fmt;
      illegal_q   <= dec_illegal;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating count of accepted illegal opcodes; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_valid_o   = out_valid_q;
  assign bus.imm_o         = imm_q;
  assign bus.fmt_o         = fmt_q;
  assign bus.illegal_o     = illegal_q;
  assign bus.illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_imm_pipe_unit.sv
// Directed bench for imm_pipe_unit: one XLEN=32/CNT_W=2 instance and one
// XLEN=64/CNT_W=8 instance driven identically, checked against a scoreboard
// of hand-derived expected immediates.
module tb_imm_pipe_unit;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [63:0] imm;
  } exp_t;

  logic clk;
  logic reset;

  imm_pipe_unit_if #(.XLEN(32), .CNT_W(2)) bus_a ();
  imm_pipe_unit_if #(.XLEN(64), .CNT_W(8)) bus_b ();

  imm_pipe_unit #(.XLEN(32), .CNT_W(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  imm_pipe_unit #(.XLEN(64), .CNT_W(8)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_asserts = 0;
  int   n_fail    = 0;
  exp_t sb_q[$];
  logic m_valid;
  int   m_cnt_a;
  int   m_cnt_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] fmt, input logic [63:0] imm);
    exp_t e;
    e.fmt = fmt;
    e.imm = imm;
    return e;
  endfunction

  // One clock cycle: drive, check combinational ready and the held entry,
  // update the scoreboard, then check counters after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic ordy, input exp_t e);
    logic acc;
    exp_t f;
    bus_a.in_valid_i = v;  bus_b.in_valid_i = v;
    bus_a.instr_i = ins;   bus_b.instr_i = ins;
    bus_a.flush_i = fl;    bus_b.flush_i = fl;
    bus_a.out_ready_i = ordy; bus_b.out_ready_i = ordy;
    #1;
    check("in_ready_a", 64'(bus_a.in_ready_o), 64'(!m_valid || ordy));
    check("in_ready_b", 64'(bus_b.in_ready_o), 64'(!m_valid || ordy));
    check("out_valid_a", 64'(bus_a.out_valid_o), 64'(m_valid));
    check("out_valid_b", 64'(bus_b.out_valid_o), 64'(m_valid));
    if (m_valid && sb_q.size() > 0) begin
      f = sb_q[0];
      check("fmt_a", 64'(bus_a.fmt_o), 64'(f.fmt));
      check("fmt_b", 64'(bus_b.fmt_o), 64'(f.fmt));
      check("imm_a", 64'(bus_a.imm_o), {32'b0, f.imm[31:0]});
      check("imm_b", bus_b.imm_o, f.imm);
      check("illegal_a", 64'(bus_a.illegal_o), 64'(f.fmt == 3'd7));
      check("illegal_b", 64'(bus_b.illegal_o), 64'(f.fmt == 3'd7));
    end
    acc = v && (!m_valid || ordy) && !fl;
    if (fl) begin
      if (m_valid) void'(sb_q.pop_front());
      m_valid = 1'b0;
    end else begin
      if (m_valid && ordy) void'(sb_q.pop_front());
      if (acc) sb_q.push_back(e);
      m_valid = acc || (m_valid && !ordy);
    end
    if (acc && e.fmt == 3'd7) begin
      if (m_cnt_a < 3) m_cnt_a++;
      if (m_cnt_b < 255) m_cnt_b++;
    end
    @(posedge clk);
    #1;
    check("cnt_a", 64'(bus_a.illegal_cnt_o), 64'(m_cnt_a));
    check("cnt_b", 64'(bus_b.illegal_cnt_o), 64'(m_cnt_b));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid_a"}, 64'(bus_a.out_valid_o), 64'd0);
    check({tag, "_valid_b"}, 64'(bus_b.out_valid_o), 64'd0);
    check({tag, "_imm_a"}, 64'(bus_a.imm_o), 64'd0);
    check({tag, "_imm_b"}, bus_b.imm_o, 64'd0);
    check({tag, "_fmt_a"}, 64'(bus_a.fmt_o), 64'd0);
    check({tag, "_fmt_b"}, 64'(bus_b.fmt_o), 64'd0);
    check({tag, "_illegal_a"}, 64'(bus_a.illegal_o), 64'd0);
    check({tag, "_cnt_a"}, 64'(bus_a.illegal_cnt_o), 64'd0);
    check({tag, "_cnt_b"}, 64'(bus_b.illegal_cnt_o), 64'd0);
    check({tag, "_ready_a"}, 64'(bus_a.in_ready_o), 64'd1);
  endtask

  exp_t none;
  exp_t csr_exp;

  initial begin
    none    = mk(3'd0, 64'd0);
`ifdef IMM_ZICSR_EN
    csr_exp = mk(3'd6, 64'h1);
`else
    csr_exp = mk(3'd0, 64'h0);
`endif
    m_valid = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    reset = 1'b1;
    bus_a.in_valid_i = 1'b0; bus_b.in_valid_i = 1'b0;
    bus_a.instr_i = '0;      bus_b.instr_i = '0;
    bus_a.flush_i = 1'b0;    bus_b.flush_i = 1'b0;
    bus_a.out_ready_i = 1'b1; bus_b.out_ready_i = 1'b1;

    #3;
    check_reset_values("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back I/S/B, then U (incl. RV64 sign extension), other formats.
    step(1'b1, 32'hFFF00093, 1'b0, 1'b1, mk(3'd1, 64'hFFFFFFFF_FFFFFFFF));
    step(1'b1, 32'hFE112E23, 1'b0, 1'b1, mk(3'd2, 64'hFFFFFFFF_FFFFFFFC));
    step(1'b1, 32'hFE000CE3, 1'b0, 1'b1, mk(3'd3, 64'hFFFFFFFF_FFFFFFF8));
    step(1'b1, 32'h123450B7, 1'b0, 1'b1, mk(3'd4, 64'h00000000_12345000));
    step(1'b1, 32'h800000B7, 1'b0, 1'b1, mk(3'd4, 64'hFFFFFFFF_80000000));
    step(1'b1, 32'h7FF00013, 1'b0, 1'b1, mk(3'd1, 64'h00000000_000007FF));
    step(1'b1, 32'h00000033, 1'b0, 1'b1, mk(3'd0, 64'h0));
    step(1'b1, 32'h3400D073, 1'b0, 1'b1, csr_exp);

    // Backpressure: hold a J entry for 3 cycles, then transfer+reload together.
    step(1'b1, 32'h0040006F, 1'b0, 1'b1, mk(3'd5, 64'h4));
    step(1'b1, 32'h00402003, 1'b0, 1'b0, none);
    step(1'b0, 32'h0,        1'b0, 1'b0, none);
    step(1'b0, 32'h0,        1'b0, 1'b0, none);
    step(1'b1, 32'h00402003, 1'b0, 1'b1, mk(3'd1, 64'h4));
    step(1'b0, 32'h0,        1'b0, 1'b1, none);

    // Illegal opcode saturation (narrow counter saturates at 3).
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h0000007F, 1'b0, 1'b1, mk(3'd7, 64'h0));
    // Illegal offered under flush: dropped and not counted.
    step(1'b1, 32'h0000007F, 1'b1, 1'b1, mk(3'd7, 64'h0));
    step(1'b0, 32'h0,        1'b0, 1'b1, none);

    // Flush with a held entry and a concurrent input.
    step(1'b1, 32'h00500093, 1'b0, 1'b0, mk(3'd1, 64'h5));
    step(1'b1, 32'h0000007F, 1'b1, 1'b0, mk(3'd7, 64'h0));
    step(1'b0, 32'h0,        1'b0, 1'b1, none);

    // Asynchronous reset between edges while an entry is held.
    step(1'b1, 32'hFFF00093, 1'b0, 1'b0, mk(3'd1, 64'hFFFFFFFF_FFFFFFFF));
    bus_a.in_valid_i = 1'b0; bus_b.in_valid_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    sb_q.delete();
    m_valid = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First accept right after reset release.
    step(1'b1, 32'h0000007F, 1'b0, 1'b1, mk(3'd7, 64'h0));
    step(1'b0, 32'h0,        1'b0, 1'b1, none);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_pipe_unit.md
# imm_pipe_unit

Registered, handshaked immediate generator for the RV32I/RV64I decode stage. It classifies a 32-bit instruction by opcode and builds the sign-extended immediate for I, S, B, U and J formats at width XLEN. It holds the result in a one-entry pipeline register with valid/ready flow control, a flush input and a saturating illegal-opcode counter. It sits between the fetch buffer and the register-read stage, and supersedes the combinational single-format extender.

## Interface
- XLEN, 32: immediate width; legal values 32 or 64.
- CNT_W, 8: width of the illegal-opcode counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  an instruction is presented on instr_i.
- in_ready_o  out  1  the stage accepts an instruction this cycle.
- instr_i  in  32  instruction word.
- flush_i  in  1  synchronous kill of the held entry and of any concurrent input.
- out_valid_o  out  1  imm_o, fmt_o and illegal_o are valid.
- out_ready_i  in  1  the consumer takes the held entry.
- imm_o  out  XLEN  generated immediate.
- fmt_o  out  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm), 7 illegal.
- illegal_o  out  1  the held entry has an unrecognised opcode.
- illegal_cnt_o  out  CNT_W  saturating count of accepted illegal opcodes.

## Operation
- Opcode is instr_i[6:0]. Decode is combinational and feeds the output register.
- Opcodes 0x13, 0x03 and 0x67 use I format: imm = sext(instr[31:20]).
- Opcode 0x23 uses S format: imm = sext({instr[31:25], instr[11:7]}).
- Opcode 0x63 uses B format: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- Opcodes 0x37 and 0x17 use U format: imm = sext({instr[31:12], 12'b0}). For XLEN=64, bit 31 replicates into bits 63:32.
- Opcode 0x6F uses J format: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Opcodes 0x33, 0x0F and 0x73 give fmt 0 and imm 0; they are legal. Opcode 0x73 behaves differently when IMM_ZICSR_EN is defined (see Configuration).
- Any other opcode gives fmt 7, imm 0 and illegal_o=1.
- Sign extension always uses instr[31].
- Accept condition: in_valid_i && in_ready_o && !flush_i.
- in_ready_o = !out_valid_o || out_ready_i. It is purely combinational and never depends on in_valid_i.
- On accept, the register loads the decode result and out_valid_o becomes 1.
- A transfer happens when out_valid_o && out_ready_i. If nothing is accepted in the same cycle, out_valid_o becomes 0.
- While out_valid_o=1 and out_ready_i=0, all outputs hold stable.
- flush_i=1 sets out_valid_o=0 next cycle, drops any input offered that cycle, and does not increment the counter. flush_i takes priority over accept and over transfer.
- illegal_cnt_o increments by 1 on each accepted illegal opcode. It saturates at 2^CNT_W−1. It is cleared only by reset.

## Timing
- Latency is 1 cycle from accept to out_valid_o. Throughput is 1 per cycle when out_ready_i is held at 1.
- Reset values: out_valid_o=0, imm_o=0, fmt_o=0, illegal_o=0, illegal_cnt_o=0. in_ready_o therefore reads 1 during and after reset.
- Asserting reset mid-operation immediately clears the held entry and the counter, without waiting for a clock edge. The first accept can occur on the first rising edge after reset deasserts.
- When an entry transfers and a new one is accepted in the same cycle, the new entry replaces the old one with no bubble.
- At counter saturation, further illegal accepts leave the counter at its maximum; there is no wrap-around.

## Configuration
- IMM_ZICSR_EN defined: opcode 0x73 with funct3 (instr[14:12]) in {5,6,7} gives fmt 6 and imm = zero-extended instr[19:15]. Opcode 0x73 with any other funct3 gives fmt 0 and imm 0.
- IMM_ZICSR_EN undefined: every 0x73 instruction gives fmt 0 and imm 0. fmt code 6 is never produced.

## Test plan
- Reset, then XLEN=32, out_ready_i=1. Apply 0xFFF00093 → fmt 1, imm 0xFFFFFFFF. Then 0xFE112E23 → fmt 2, imm 0xFFFFFFFC. Then 0xFE000CE3 → fmt 3, imm 0xFFFFFFF8. Each appears one cycle after its accept, back-to-back with no bubbles.
- XLEN=64: 0x123450B7 → fmt 4, imm 0x0000000012345000. 0x800000B7 → imm 0xFFFFFFFF80000000.
- Backpressure: accept 0x0040006F, then hold out_ready_i=0 for 3 cycles. Required: in_ready_o=0, outputs stable at fmt 5, imm 0x00000004. Release out_ready_i with a new input offered the same cycle → transfer and reload in that cycle.
- Illegal opcodes, CNT_W=2: 5 accepts of 0x0000007F → illegal_o=1, fmt 7, counter sequence 1, 2, 3, 3, 3. An illegal opcode offered while flush_i=1 leaves the count unchanged.
- Flush and reset: with a held entry, assert flush_i together with in_valid_i → out_valid_o=0 next cycle and the input is dropped. Assert reset between clock edges while out_valid_o=1 → all outputs return to their reset values immediately.
- IMM_ZICSR_EN defined: 0x3400D073 → fmt 6, imm 0x1. IMM_ZICSR_EN undefined: the same word → fmt 0, imm 0.
